// File: rtl/imm_gen_pipe_pkg.sv
// ============================================================================
//  Module      : imm_gen_pipe_pkg
//  Description : Shared mode codes, prefix FSM states and widths for the
//                registered immediate generator.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package imm_gen_pipe_pkg;

    // Extend-mode codes carried on the 4-bit sel input
    localparam logic [3:0] MODE_Z5   = 4'd0;
    localparam logic [3:0] MODE_Z8   = 4'd1;
    localparam logic [3:0] MODE_S5A  = 4'd2;
    localparam logic [3:0] MODE_S5B  = 4'd3;
    localparam logic [3:0] MODE_S8A  = 4'd4;
    localparam logic [3:0] MODE_S8B  = 4'd5;
    localparam logic [3:0] MODE_S11A = 4'd6;
    localparam logic [3:0] MODE_S11B = 4'd7;
    localparam logic [3:0] MODE_HI8  = 4'd8;
    localparam logic [3:0] MODE_PFX  = 4'd9;

    // Width of the held upper-immediate prefix
    localparam int PFX_W = 11;

    // Prefix FSM: IDLE = no prefix held, HELD = prefix waits for next instr
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } pfx_state_e;

endpackage : imm_gen_pipe_pkg

`default_nettype wire

// File: rtl/imm_gen_pipe_ext_core.sv
// ============================================================================
//  Module      : imm_gen_pipe_ext_core
//  Description : Combinational extend mux. Produces the immediate for the
//                selected mode, splicing in a held prefix when one is active,
//                and flags illegal modes / sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_gen_pipe_ext_core
    import imm_gen_pipe_pkg::*;
#(
    parameter int DW        = 16,
    parameter int EN_PREFIX = 1
) (
    input  logic [15:0]      instr,
    input  logic [3:0]       sel,
    input  logic             pfx_hit,
    input  logic [PFX_W-1:0] pfx,
    output logic [DW-1:0]    imm,
    output logic             bad
);

    logic [DW-1:0] w_z5;
    logic [DW-1:0] w_z8;
    logic [DW-1:0] w_s5;
    logic [DW-1:0] w_s8;
    logic [DW-1:0] w_s11;
    logic [DW-1:0] w_hi8;
    logic [DW-1:0] w_pfx_ext;
    logic [DW-1:0] w_pfx_cat;
    logic          w_unused;

    assign w_z5  = {{(DW-5){1'b0}}, instr[4:0]};
    assign w_z8  = {{(DW-8){1'b0}}, instr[7:0]};
    assign w_s5  = {{(DW-5){instr[4]}}, instr[4:0]};
    assign w_s8  = {{(DW-8){instr[7]}}, instr[7:0]};
    assign w_s11 = {{(DW-11){instr[10]}}, instr[10:0]};

    // High-byte mode: sign-extended byte shifted up by 8 (top bits drop off)
    assign w_hi8 = {w_s8[DW-9:0], 8'h00};

    // Prefix is sign-extended to DW, then its top 5 bits make room for instr[4:0]
    assign w_pfx_ext = {{(DW-PFX_W){pfx[PFX_W-1]}}, pfx};
    assign w_pfx_cat = {w_pfx_ext[DW-6:0], instr[4:0]};

    // Bits that no mode consumes
    assign w_unused = ^{instr[15:11], w_pfx_ext[DW-1:DW-5]};

    // Mode select; a held prefix overrides modes 0-7, mode 8 flags the broken sequence
    always_comb begin
        imm = '0;
        bad = 1'b0;
        if (pfx_hit && (sel <= MODE_S11B)) begin
            imm = w_pfx_cat;
        end else begin
            case (sel)
                MODE_Z5:              imm = w_z5;
                MODE_Z8:              imm = w_z8;
                MODE_S5A, MODE_S5B:   imm = w_s5;
                MODE_S8A, MODE_S8B:   imm = w_s8;
                MODE_S11A, MODE_S11B: imm = w_s11;
                MODE_HI8: begin
                    imm = w_hi8;
                    bad = pfx_hit;
                end
                MODE_PFX: begin
                    // Only reaches the output register when prefixing is disabled
                    bad = (EN_PREFIX == 0);
                end
                default: begin
                    bad = 1'b1;
                end
            endcase
        end
    end

endmodule : imm_gen_pipe_ext_core

`default_nettype wire

// File: rtl/imm_gen_pipe.sv
// ============================================================================
//  Module      : imm_gen_pipe
//  Description : Registered immediate generator between decode and execute.
//                Single output register with valid/ready on both sides, a
//                prefix FSM holding upper immediate bits, and a sync flush.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_gen_pipe
    import imm_gen_pipe_pkg::*;
#(
    parameter int DW        = 16,
    parameter int EN_PREFIX = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [15:0]   instr,
    input  logic [3:0]    sel,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] Imm,
    output logic          err
);

    pfx_state_e       state_q;
    pfx_state_e       state_d;
    logic [PFX_W-1:0] pfx_q;
    logic [PFX_W-1:0] pfx_d;
    logic             out_valid_q;
    logic [DW-1:0]    imm_q;
    logic             err_q;

    logic             w_in_ready;
    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_is_pfx;
    logic [DW-1:0]    w_core_imm;
    logic             w_core_bad;

    // No skid buffer: accept only when the output slot is empty or draining
    assign w_in_ready = !out_valid_q || out_ready;
    assign w_in_fire  = in_valid && w_in_ready && !flush;
    assign w_out_fire = out_valid_q && out_ready;
    assign w_is_pfx   = (EN_PREFIX != 0) && (sel == MODE_PFX);

    assign in_ready  = w_in_ready;
    assign out_valid = out_valid_q;
    assign Imm       = imm_q;
    assign err       = err_q;

    imm_gen_pipe_ext_core #(
        .DW        (DW),
        .EN_PREFIX (EN_PREFIX)
    ) u_ext_core (
        .instr   (instr),
        .sel     (sel),
        .pfx_hit (state_q == ST_HELD),
        .pfx     (pfx_q),
        .imm     (w_core_imm),
        .bad     (w_core_bad)
    );

    // Prefix FSM next state: flush wins, any accepted non-prefix consumes the prefix
    always_comb begin
        state_d = state_q;
        pfx_d   = pfx_q;
        if (flush) begin
            state_d = ST_IDLE;
            pfx_d   = '0;
        end else if (w_in_fire) begin
            if (w_is_pfx) begin
                state_d = ST_HELD;
                pfx_d   = instr[PFX_W-1:0];
            end else begin
                state_d = ST_IDLE;
                pfx_d   = '0;
            end
        end
    end

    // Prefix FSM state and held prefix
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pfx_q   <= '0;
        end else begin
            state_q <= state_d;
            pfx_q   <= pfx_d;
        end
    end

    // Output register: load on a producing input, clear on drain or flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            imm_q       <= '0;
            err_q       <= 1'b0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (w_in_fire && !w_is_pfx) begin
            out_valid_q <= 1'b1;
            imm_q       <= w_core_imm;
            err_q       <= w_core_bad;
        end else if (w_out_fire) begin
            out_valid_q <= 1'b0;
        end
    end

endmodule : imm_gen_pipe

`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
// ============================================================================
//  Module      : tb_imm_gen_pipe
//  Description : Self-checking bench for imm_gen_pipe at DW=16 and DW=32,
//                both instances driven by the same stimulus and checked
//                against a reference model feeding a scoreboard queue.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imm_gen_pipe;

    typedef struct packed {
        logic [31:0] imm;
        logic        err;
    } entry_t;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [15:0] instr;
    logic [3:0]  sel;
    logic        out_ready;

    logic        in_ready16;
    logic        out_valid16;
    logic [15:0] imm16;
    logic        err16;
    logic        in_ready32;
    logic        out_valid32;
    logic [31:0] imm32;
    logic        err32;

    int          n_tests;
    int          n_fail;

    entry_t      sb[$];
    logic        m_held;
    logic [10:0] m_pfx;

    imm_gen_pipe #(.DW(16), .EN_PREFIX(1)) u_dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready16),
        .instr     (instr),
        .sel       (sel),
        .out_valid (out_valid16),
        .out_ready (out_ready),
        .Imm       (imm16),
        .err       (err16)
    );

    imm_gen_pipe #(.DW(32), .EN_PREFIX(1)) u_dut32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready32),
        .instr     (instr),
        .sel       (sel),
        .out_valid (out_valid32),
        .out_ready (out_ready),
        .Imm       (imm32),
        .err       (err32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference immediate at 32 bits; the 16-bit result is its low half
    function automatic entry_t calc(input logic [3:0] s, input logic [15:0] ins,
                                    input logic held, input logic [10:0] p);
        entry_t e;
        e.imm = 32'd0;
        e.err = 1'b0;
        if (held && (s <= 4'd7)) begin
            e.imm = {{16{p[10]}}, p, ins[4:0]};
        end else begin
            case (s)
                4'd0:       e.imm = {27'd0, ins[4:0]};
                4'd1:       e.imm = {24'd0, ins[7:0]};
                4'd2, 4'd3: e.imm = {{27{ins[4]}}, ins[4:0]};
                4'd4, 4'd5: e.imm = {{24{ins[7]}}, ins[7:0]};
                4'd6, 4'd7: e.imm = {{21{ins[10]}}, ins[10:0]};
                4'd8: begin
                    e.imm = {{16{ins[7]}}, ins[7:0], 8'h00};
                    e.err = held;
                end
                default: begin
                    e.imm = 32'd0;
                    e.err = 1'b1;
                end
            endcase
        end
        return e;
    endfunction

    // One clock: drive at negedge, check outputs, then advance the model
    task automatic cyc(input logic v, input logic [3:0] s, input logic [15:0] ins,
                       input logic ordy, input logic fl);
        logic   m_valid;
        entry_t e;
        @(negedge clk);
        in_valid  = v;
        sel       = s;
        instr     = ins;
        out_ready = ordy;
        flush     = fl;
        #1;
        m_valid = (sb.size() != 0);
        chk("out_valid16", 32'(out_valid16), 32'(m_valid));
        chk("out_valid32", 32'(out_valid32), 32'(m_valid));
        chk("in_ready16", 32'(in_ready16), 32'(!m_valid || ordy));
        chk("in_ready32", 32'(in_ready32), 32'(!m_valid || ordy));
        if (m_valid) begin
            chk("imm16", 32'(imm16), 32'(sb[0].imm[15:0]));
            chk("imm32", imm32, sb[0].imm);
            chk("err16", 32'(err16), 32'(sb[0].err));
            chk("err32", 32'(err32), 32'(sb[0].err));
        end
        if (fl) begin
            sb.delete();
            m_held = 1'b0;
            m_pfx  = 11'd0;
        end else begin
            if (m_valid && ordy) begin
                void'(sb.pop_front());
            end
            if (v && (!m_valid || ordy)) begin
                if (s == 4'd9) begin
                    m_held = 1'b1;
                    m_pfx  = ins[10:0];
                end else begin
                    e = calc(s, ins, m_held, m_pfx);
                    sb.push_back(e);
                    m_held = 1'b0;
                    m_pfx  = 11'd0;
                end
            end
        end
    endtask

    // Asynchronous reset asserted mid-cycle, away from any clock edge
    task automatic async_reset();
        in_valid = 1'b0;
        flush    = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid16", 32'(out_valid16), 32'd0);
        chk("rst_out_valid32", 32'(out_valid32), 32'd0);
        chk("rst_imm16", 32'(imm16), 32'd0);
        chk("rst_imm32", imm32, 32'd0);
        chk("rst_err16", 32'(err16), 32'd0);
        chk("rst_err32", 32'(err32), 32'd0);
        sb.delete();
        m_held = 1'b0;
        m_pfx  = 11'd0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) cyc(1'b0, 4'd0, 16'h0000, 1'b1, 1'b0);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        m_held    = 1'b0;
        m_pfx     = 11'd0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        instr     = 16'h0000;
        sel       = 4'd0;
        out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("reset_out_valid16", 32'(out_valid16), 32'd0);
        chk("reset_out_valid32", 32'(out_valid32), 32'd0);
        chk("reset_imm16", 32'(imm16), 32'd0);
        chk("reset_imm32", imm32, 32'd0);
        chk("reset_err16", 32'(err16), 32'd0);
        chk("reset_in_ready16", 32'(in_ready16), 32'd1);
        rst_n = 1'b1;

        // Modes 0-8 back to back on one instruction word
        for (int m = 0; m <= 8; m++) cyc(1'b1, 4'(m), 16'h0795, 1'b1, 1'b0);
        drain();

        // Prefix then mode 0: single output 8033 / FFFF8033
        cyc(1'b1, 4'd9, 16'h0401, 1'b1, 1'b0);
        cyc(1'b1, 4'd0, 16'h0013, 1'b1, 1'b0);
        drain();

        // Back-pressure: 3 stalled cycles, then the stream resumes
        cyc(1'b1, 4'd1, 16'h00A1, 1'b1, 1'b0);
        cyc(1'b1, 4'd2, 16'h0012, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 4'd4, 16'h0083, 1'b0, 1'b0);
        cyc(1'b1, 4'd4, 16'h0083, 1'b1, 1'b0);
        cyc(1'b1, 4'd6, 16'h0400, 1'b1, 1'b0);
        cyc(1'b1, 4'd0, 16'h001F, 1'b1, 1'b0);
        drain();

        // Prefix then mode 8 flags err and drops the prefix
        cyc(1'b1, 4'd9, 16'h0123, 1'b1, 1'b0);
        cyc(1'b1, 4'd8, 16'h00FF, 1'b1, 1'b0);
        cyc(1'b1, 4'd0, 16'h0003, 1'b1, 1'b0);
        drain();

        // Prefix replaced while held, then consumed
        cyc(1'b1, 4'd9, 16'h0555, 1'b1, 1'b0);
        cyc(1'b1, 4'd9, 16'h0401, 1'b1, 1'b0);
        cyc(1'b1, 4'd3, 16'h0013, 1'b1, 1'b0);
        drain();

        // Reserved modes, including while a prefix is held
        cyc(1'b1, 4'd12, 16'h1234, 1'b1, 1'b0);
        cyc(1'b1, 4'd15, 16'hFFFF, 1'b1, 1'b0);
        cyc(1'b1, 4'd9, 16'h07FF, 1'b1, 1'b0);
        cyc(1'b1, 4'd10, 16'h0001, 1'b1, 1'b0);
        cyc(1'b1, 4'd0, 16'h0004, 1'b1, 1'b0);
        drain();

        // Flush while held, with an input presented in the flush cycle
        cyc(1'b1, 4'd9, 16'h07FF, 1'b1, 1'b0);
        cyc(1'b1, 4'd0, 16'h0013, 1'b1, 1'b1);
        cyc(1'b1, 4'd0, 16'h0003, 1'b1, 1'b0);
        drain();

        // Flush with a pending, stalled output
        cyc(1'b1, 4'd1, 16'h00AA, 1'b1, 1'b0);
        cyc(1'b0, 4'd0, 16'h0000, 1'b0, 1'b0);
        cyc(1'b0, 4'd0, 16'h0000, 1'b0, 1'b1);
        drain();

        // Async reset with a stalled output entry
        cyc(1'b1, 4'd5, 16'h0080, 1'b1, 1'b0);
        cyc(1'b0, 4'd0, 16'h0000, 1'b0, 1'b0);
        async_reset();
        drain();

        // Async reset with a held prefix; mode 0 afterwards has no prefix bits
        cyc(1'b1, 4'd9, 16'h07FF, 1'b1, 1'b0);
        cyc(1'b0, 4'd0, 16'h0000, 1'b1, 1'b0);
        async_reset();
        cyc(1'b1, 4'd0, 16'h0003, 1'b1, 1'b0);
        drain();

        // Random stream with random back-pressure and occasional flush
        for (int i = 0; i < 200; i++) begin
            cyc(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom),
                1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0));
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_imm_gen_pipe

`default_nettype wire
